i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
// - Clocked I2C target (peripheral) exposing a NUM_REGS x 8 register window to the I2C bus.
// - SCL/SDA are oversampled on clk, synchronised and glitch-filtered.
// - Supports repeated START, register-pointer auto-increment and multi-byte read/write bursts.
// - Sits between the board I2C pins and the FPGA control register bank.
// - Generalises the single-byte async peripheral: one clock domain, parametrised address/depth/filtering.
// PARAMETERS
// ADDRESS      7'h42  7-bit target address
// NUM_REGS     16     register window depth; power of two, 2..256
// SYNC_STAGES  2      synchroniser flops per line (>=2)
// FILTER_LEN   3      consecutive equal samples required to accept a new line level (>=1)
// PORTS
// clk      in     1                 system clock, >= 16x SCL rate
// rst      in     1                 asynchronous reset, active-high
// scl      in     1                 I2C clock pin (target never stretches)
// sda      inout  1                 I2C data pin; driven only to 0, otherwise 'z
// rd_data  in     8                 host data for rd_addr, combinational from register bank
// rd_addr  out    $clog2(NUM_REGS)  current register pointer
// wr_en    out    1                 one-cycle write strobe
// wr_addr  out    $clog2(NUM_REGS)  write address, valid with wr_en
// wr_data  out    8                 write data, valid with wr_en
// rw       out    1                 direction of last matched transfer; 0 read, 1 write (reference polarity)
// busy     out    1                 high from matched address ACK until STOP/START/NACK
// BEHAVIOUR
// - Reset: all outputs 0, pointer 0, state IDLE, sda released ('z) asynchronously, same cycle.
// - Line filter: level accepted after SYNC_STAGES+FILTER_LEN clk; yields scl_rise/scl_fall/start/stop pulses.
// - START = filtered SDA fall while SCL high; STOP = SDA rise while SCL high.
// - Shift timing: SDA sampled on scl_rise, MSB first. Target drive changes only on scl_fall.
// - States:
//     IDLE -> ADDR on START.
//     ADDR: 8 bits; at 8th rise -> ADDR_ACK (match) or IDLE (no match, never drives).
//     ADDR_ACK: drive 0 from fall after bit 8 to next fall.
//       R/W=0 -> PTR; R/W=1 -> RDATA, latch rd_data at ACK-release fall.
//     PTR: 8 bits -> pointer <= byte mod NUM_REGS; -> PTR_ACK (ACK) -> WDATA.
//     WDATA: 8 bits; wr_en pulse 1 clk after 8th rise with wr_addr=pointer; pointer++ -> WDATA_ACK -> WDATA.
//     RDATA: drive shift MSB first (0 -> pull low, 1 -> release); after 8 bits -> CACK, release sda.
//     CACK: sample at rise; 0 (ACK) -> pointer++, latch rd_data, RDATA; 1 (NACK) -> IDLE.
// - Pointer wraps NUM_REGS-1 -> 0 on both read and write; pointer persists across transfers until rst.
// - Repeated START in any state: release sda, bit counter 0, -> ADDR; pointer kept.
// - STOP in any state -> IDLE, sda released; partial byte discarded, no wr_en.
// - START/STOP within the same filtered sample as an SCL edge: START/STOP wins.
// - Arithmetic: 3-bit bit counter; pointer width $clog2(NUM_REGS), natural wrap.
// STRUCTURE
// - Package i2c_pkg holds:
//     i2c_state_e: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, CACK.
//     Constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_WRITE=1'b0, I2C_READ=1'b1.
// - Sub-module i2c_line_filter: synchroniser + glitch filter + rise/fall pulses; instantiated for scl and sda.
// TESTING
// 1. START, 0x84(W), ptr 0x03, 0xA5, 0x5A, STOP -> three ACKs; wr_en (3,A5) then (4,5A); rw=1.
// 2. Write ptr 0x0F, then Sr, 0x85(R), read 2 bytes ACK/NACK, host rd_data=addr*0x11
//    -> bus bytes FF, 00; target released after NACK.
// 3. START, 0x86 (addr 0x43) -> sda never driven; busy stays 0; no wr_en.
// 4. Write ptr 0x0F, data 11, 22 -> wr_addr 15 then 0 (wrap); ptr 0x23 -> pointer 3.
// 5. 1-clk SCL/SDA glitches during data byte -> no extra bits; byte 0xC3 written intact.
// 6. rst pulse during ADDR_ACK low drive -> sda 'z same cycle; next START 0x84 transfer succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared state encoding and bus-level constants for the I2C register target.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      CACK
   } i2c_state_e;

   localparam logic I2C_ACK   = 1'b0;
   localparam logic I2C_NACK  = 1'b1;
   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus majority-free run-length glitch filter for one open-drain line.
// Produces the accepted level and single-cycle rise/fall pulses aligned with it.
module i2c_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   sampled;

   assign sampled = sync_q[SYNC_STAGES-1];

   // A new level is taken only after FILTER_LEN consecutive differing samples.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sampled != level_q) begin
         if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            level_d = sampled;
            rise_d  = sampled;
            fall_d  = !sampled;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Idle bus level is high, so reset to 1 to avoid a spurious edge on release.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '1;
         cnt_q   <= '0;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], line_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// Oversampled I2C target exposing a NUM_REGS x 8 register window with pointer
// auto-increment, repeated START and multi-byte bursts.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDRESS     = 7'h42,
   parameter int         NUM_REGS    = 16,
   parameter int         SYNC_STAGES = 2,
   parameter int         FILTER_LEN  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        scl,
   inout  wire                         sda,
   input  logic [7:0]                  rd_data,
   output logic [$clog2(NUM_REGS)-1:0] rd_addr,
   output logic                        wr_en,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [7:0]                  wr_data,
   output logic                        rw,
   output logic                        busy
);

   localparam int PW = $clog2(NUM_REGS);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   i2c_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    byte_in;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          sda_oe_q, sda_oe_d;
   logic          rw_q, rw_d;
   logic          busy_q, busy_d;
   logic          wr_en_q, wr_en_d;
   logic [PW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk_i(clk), .rst_i(rst), .line_i(scl),
      .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk_i(clk), .rst_i(rst), .line_i(sda),
      .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   // SCL counts as high if it is high now or was high just before a same-cycle fall.
   assign start_det = sda_fall && (scl_lvl || scl_fall);
   assign stop_det  = sda_rise && (scl_lvl || scl_fall);
   assign byte_in   = {shift_q[6:0], sda_lvl};

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      rw_d      = rw_q;
      busy_d    = busy_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (stop_det) begin
         state_d   = IDLE;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_det) begin
         state_d   = ADDR;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_in[7:1] == ADDRESS) begin
                     state_d = ADDR_ACK;
                     busy_d  = 1'b1;
                     rw_d    = (byte_in[0] == I2C_WRITE);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            // First fall starts the ACK drive, second fall ends it.
            ADDR_ACK: if (scl_fall) begin
               if (!sda_oe_q) begin
                  sda_oe_d = 1'b1;
               end else if (shift_q[0] == I2C_READ) begin
                  state_d   = RDATA;
                  bit_cnt_d = '0;
                  shift_d   = rd_data;
                  sda_oe_d  = !rd_data[7];
               end else begin
                  state_d   = PTR;
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b0;
               end
            end
            PTR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  ptr_d   = byte_in[PW-1:0];
                  state_d = PTR_ACK;
               end
            end
            PTR_ACK, WDATA_ACK: if (scl_fall) begin
               if (!sda_oe_q) begin
                  sda_oe_d = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  state_d   = WDATA;
                  bit_cnt_d = '0;
               end
            end
            WDATA: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = byte_in;
                  ptr_d     = ptr_q + 1'b1;
                  state_d   = WDATA_ACK;
               end
            end
            // A fall with no bits clocked yet follows a controller ACK: load the next byte.
            RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     shift_d  = rd_data;
                     sda_oe_d = !rd_data[7];
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = !shift_q[6];
                  end
               end else if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = CACK;
                  end
               end
            end
            CACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
               end else if (scl_rise) begin
                  if (sda_lvl == I2C_NACK) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     ptr_d     = ptr_q + 1'b1;
                     bit_cnt_d = '0;
                     state_d   = RDATA;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ptr_q     <= '0;
         sda_oe_q  <= 1'b0;
         rw_q      <= 1'b0;
         busy_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         rw_q      <= rw_d;
         busy_q    <= busy_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign sda     = sda_oe_q ? I2C_ACK : 1'bz;
   assign rd_addr = ptr_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign rw      = rw_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged controller, write/read scoreboards.
module tb_i2c_target_regs;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       host_sda_low = 1'b0;
   wire        sda;
   logic [7:0] rd_data;
   logic [3:0] rd_addr;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       rw;
   logic       busy;

   int         n_cmp = 0;
   int         n_fail = 0;
   int         tgt_low_cnt = 0;
   int         busy_cnt = 0;
   logic [11:0] exp_wr_q[$];
   logic [7:0]  exp_rd_q[$];
   logic [11:0] exp_wr;
   logic [7:0]  exp_rd;
   logic        ack;
   logic        dummy;
   logic [7:0]  rbyte;
   int          c0, b0;

   pullup (sda);
   assign sda = host_sda_low ? 1'b0 : 1'bz;
   assign rd_data = {4'h0, rd_addr} * 8'h11;

   always #5 clk = ~clk;

   i2c_target_regs #(
      .ADDRESS(7'h42), .NUM_REGS(16), .SYNC_STAGES(2), .FILTER_LEN(3)
   ) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda), .rd_data(rd_data),
      .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rw(rw), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!host_sda_low && sda === 1'b0) tgt_low_cnt <= tgt_low_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (wr_en) begin
         if (exp_wr_q.size() == 0) begin
            check("wr_unexpected", {31'h0, wr_en}, 32'h0);
         end else begin
            exp_wr = exp_wr_q.pop_front();
            check("wr_txn", {20'h0, wr_addr, wr_data}, {20'h0, exp_wr});
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: observed no end of run, required finish within 2ms");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clock_bit(input logic v, input logic glitch, output logic s);
      tick(8);
      host_sda_low = ~v;
      if (glitch) begin
         tick(3); scl = 1'b1; tick(1); scl = 1'b0; tick(4);
      end else begin
         tick(8);
      end
      scl = 1'b1;
      tick(8);
      s = sda;
      if (glitch) begin
         host_sda_low = ~host_sda_low; tick(1); host_sda_low = ~host_sda_low; tick(7);
      end else begin
         tick(8);
      end
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic glitch, output logic a);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], glitch, s);
      clock_bit(1'b1, 1'b0, a);
   endtask

   task automatic read_byte(input logic host_ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, 1'b0, s);
         b[i] = s;
      end
      clock_bit(host_ack, 1'b0, s);
   endtask

   task automatic i2c_start();
      host_sda_low = 1'b0; tick(8);
      scl = 1'b1;          tick(8);
      host_sda_low = 1'b1; tick(8);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(8);
      host_sda_low = 1'b1; tick(8);
      scl = 1'b1;          tick(8);
      host_sda_low = 1'b0; tick(8);
   endtask

   initial begin
      rst = 1'b1;
      tick(4);
      check("rst_sda", {31'h0, sda}, 32'h1);
      check("rst_rd_addr", {28'h0, rd_addr}, 32'h0);
      check("rst_wr_en", {31'h0, wr_en}, 32'h0);
      check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
      check("rst_wr_data", {24'h0, wr_data}, 32'h0);
      check("rst_rw", {31'h0, rw}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      tick(10);

      // Basic write burst
      exp_wr_q.push_back({4'd3, 8'hA5});
      exp_wr_q.push_back({4'd4, 8'h5A});
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t1_addr_ack", {31'h0, ack}, 32'h0);
      check("t1_busy", {31'h0, busy}, 32'h1);
      send_byte(8'h03, 1'b0, ack); check("t1_ptr_ack", {31'h0, ack}, 32'h0);
      send_byte(8'hA5, 1'b0, ack); check("t1_d0_ack", {31'h0, ack}, 32'h0);
      send_byte(8'h5A, 1'b0, ack); check("t1_d1_ack", {31'h0, ack}, 32'h0);
      i2c_stop();
      check("t1_rw", {31'h0, rw}, 32'h1);
      check("t1_busy_stop", {31'h0, busy}, 32'h0);
      check("t1_ptr", {28'h0, rd_addr}, 32'd5);

      // Pointer write, repeated START, two-byte read with ACK then NACK
      exp_rd_q.push_back(8'hFF);
      exp_rd_q.push_back(8'h00);
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t2_addr_ack", {31'h0, ack}, 32'h0);
      send_byte(8'h0F, 1'b0, ack); check("t2_ptr_ack", {31'h0, ack}, 32'h0);
      i2c_start();
      send_byte(8'h85, 1'b0, ack); check("t2_raddr_ack", {31'h0, ack}, 32'h0);
      check("t2_rw", {31'h0, rw}, 32'h0);
      read_byte(1'b0, rbyte);
      exp_rd = exp_rd_q.pop_front();
      check("t2_rd0", {24'h0, rbyte}, {24'h0, exp_rd});
      read_byte(1'b1, rbyte);
      exp_rd = exp_rd_q.pop_front();
      check("t2_rd1", {24'h0, rbyte}, {24'h0, exp_rd});
      tick(4);
      check("t2_release", {31'h0, sda}, 32'h1);
      check("t2_busy_nack", {31'h0, busy}, 32'h0);
      i2c_stop();
      check("t2_ptr", {28'h0, rd_addr}, 32'h0);

      // Foreign address: no drive, no busy, no write
      c0 = tgt_low_cnt;
      b0 = busy_cnt;
      i2c_start();
      send_byte(8'h86, 1'b0, ack); check("t3_addr_nack", {31'h0, ack}, 32'h1);
      send_byte(8'h55, 1'b0, ack); check("t3_data_nack", {31'h0, ack}, 32'h1);
      i2c_stop();
      check("t3_no_drive", tgt_low_cnt - c0, 32'h0);
      check("t3_no_busy", busy_cnt - b0, 32'h0);

      // Pointer wrap on write, then pointer taken modulo depth
      exp_wr_q.push_back({4'd15, 8'h11});
      exp_wr_q.push_back({4'd0, 8'h22});
      i2c_start();
      send_byte(8'h84, 1'b0, ack);
      send_byte(8'h0F, 1'b0, ack);
      send_byte(8'h11, 1'b0, ack);
      send_byte(8'h22, 1'b0, ack); check("t4_d1_ack", {31'h0, ack}, 32'h0);
      i2c_stop();
      check("t4_ptr_wrap", {28'h0, rd_addr}, 32'd1);
      i2c_start();
      send_byte(8'h84, 1'b0, ack);
      send_byte(8'h23, 1'b0, ack); check("t4_ptr23_ack", {31'h0, ack}, 32'h0);
      i2c_stop();
      check("t4_ptr_mod", {28'h0, rd_addr}, 32'd3);

      // Single-clock glitches on both lines within a data byte
      exp_wr_q.push_back({4'd5, 8'hC3});
      i2c_start();
      send_byte(8'h84, 1'b0, ack);
      send_byte(8'h05, 1'b0, ack);
      send_byte(8'hC3, 1'b1, ack); check("t5_glitch_ack", {31'h0, ack}, 32'h0);
      i2c_stop();
      check("t5_ptr", {28'h0, rd_addr}, 32'd6);

      // Reset while the target is pulling SDA low for the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] a84;
         a84 = 8'h84;
         clock_bit(a84[i], 1'b0, dummy);
      end
      tick(8);
      host_sda_low = 1'b0;
      tick(4);
      check("t6_ack_drive", {31'h0, sda}, 32'h0);
      rst = 1'b1;
      #1;
      check("t6_rst_release", {31'h0, sda}, 32'h1);
      check("t6_rst_busy", {31'h0, busy}, 32'h0);
      scl = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(10);
      check("t6_ptr_reset", {28'h0, rd_addr}, 32'h0);
      exp_wr_q.push_back({4'd7, 8'h99});
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t6_addr_ack", {31'h0, ack}, 32'h0);
      send_byte(8'h07, 1'b0, ack);
      send_byte(8'h99, 1'b0, ack); check("t6_data_ack", {31'h0, ack}, 32'h0);
      i2c_stop();
      tick(4);
      check("wr_queue_empty", exp_wr_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
